input_port_ctrl: RTL and testbench

- Multi-channel memory-mapped input peripheral; parametrised successor of the single-word switch input buffer on the LSU load path.
- Each channel takes a 32-bit raw asynchronous input (switches/buttons/GPIO) and passes it through a synchroniser and a per-channel debouncer.
- Debounced state and sticky change flags are exposed to loads through a registered read port with RISC-V load formatting (LB/LBU/LH/LHU/LW), byte-offset aware.

---
 rtl/input_port_pkg.sv | 40 ++++
 rtl/input_debounce.sv | 60 ++++++
 rtl/input_port_ctrl.sv | 148 ++++++++++++++
 tb/tb_input_port_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_pkg.sv
// Shared definitions for the input_port_ctrl peripheral: load-type codes,
// address-region codes, and the RISC-V load formatter used by the read port.
package input_port_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CHG  = 1'b1;

    // Returns {misalign, data}. Misaligned or illegal loads return zero data.
    function automatic logic [32:0] load_fmt(input logic [31:0] word,
                                             input logic [1:0]  offset,
                                             input logic [2:0]  func3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [32:0] r;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (func3)
            LB:      r = {1'b0, {24{b[7]}}, b};
            LBU:     r = {1'b0, 24'h000000, b};
            LH:      r = offset[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
            LHU:     r = offset[0] ? {1'b1, 32'h0} : {1'b0, 16'h0000, h};
            LW:      r = (offset != 2'b00) ? {1'b1, 32'h0} : {1'b0, word};
            default: r = 33'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One 32-bit input channel: multi-flop synchroniser, candidate/counter
// debouncer and committed stable value. commit pulses for the single cycle
// whose closing edge loads stable; diff is the bit-change that commit carries.
module input_debounce
    import input_port_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] raw,
    output logic [31:0] stable,
    output logic        commit,
    output logic [31:0] diff
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0]      sync_r [SYNC_STAGES];
    logic [31:0]      sync_s;
    logic [31:0]      cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      stable_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift, candidate tracking, saturating stability counter and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 32'h0;
            end
            cand_r   <= 32'h0;
            cnt_r    <= '0;
            stable_r <= 32'h0;
        end else begin
            sync_r[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            if (sync_s != cand_r) begin
                cand_r <= sync_s;
                cnt_r  <= '0;
            end else if (cnt_r < CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    stable_r <= cand_r;
                end
            end
        end
    end

    assign stable = stable_r;
    assign commit = (sync_s == cand_r) && (cnt_r == CNT_LAST);
    assign diff   = stable_r ^ cand_r;

endmodule

// File: rtl/input_port_ctrl.sv
// Multi-channel debounced input peripheral with sticky change flags and a
// registered RISC-V formatted load port. Optional feature macro
// INPUT_PORT_IRQ_EN adds per-channel irq masks (written through the data
// region) and a registered o_irq output.
module input_port_ctrl
    import input_port_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = $clog2(NUM_CH) + 3
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic [NUM_CH*32-1:0] i_raw,
    input  logic                 i_rden,
    input  logic                 i_wren,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [2:0]           i_func3,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_data,
    output logic                 o_valid,
    output logic                 o_misalign
`ifdef INPUT_PORT_IRQ_EN
    ,
    output logic                 o_irq
`endif
);

    logic [31:0]       stable_s [NUM_CH];
    logic [31:0]       diff_s   [NUM_CH];
    logic [NUM_CH-1:0] commit_s;
    logic [31:0]       chg_r    [NUM_CH];
    logic [31:0]       clr_s    [NUM_CH];
    logic [ADDR_W-1:0] ch_s;
    logic [31:0]       word_s;
    logic [32:0]       fmt_s;

    assign ch_s = i_addr >> 3'd3;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            input_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (i_clk),
                .rst_n  (rst_n),
                .raw    (i_raw[32*g +: 32]),
                .stable (stable_s[g]),
                .commit (commit_s[g]),
                .diff   (diff_s[g])
            );
        end
    endgenerate

    // Write-1-to-clear masks, routed only to the addressed in-range channel.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            clr_s[k] = (i_wren && (i_addr[2] == REG_CHG) && (ch_s == ADDR_W'(k)))
                       ? i_wdata : 32'h0;
        end
    end

    // Sticky change flags: clear first, then OR in the commit diff so a set wins.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                chg_r[k] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                chg_r[k] <= (chg_r[k] & ~clr_s[k]) | (commit_s[k] ? diff_s[k] : 32'h0);
            end
        end
    end

    // Source word selection; out-of-range channels read as zero.
    always_comb begin
        word_s = 32'h0;
        for (int k = 0; k < NUM_CH; k++) begin
            word_s = (ch_s == ADDR_W'(k))
                     ? ((i_addr[2] == REG_CHG) ? chg_r[k] : stable_s[k])
                     : word_s;
        end
    end

    assign fmt_s = load_fmt(word_s, i_addr[1:0], i_func3);

    // Registered read port: data/misalign hold between loads, valid pulses per load.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data     <= 32'h0;
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            o_valid <= i_rden;
            if (i_rden) begin
                o_data     <= fmt_s[31:0];
                o_misalign <= fmt_s[32];
            end else begin
                o_data     <= o_data;
                o_misalign <= o_misalign;
            end
        end
    end

`ifdef INPUT_PORT_IRQ_EN
    logic [31:0] mask_r [NUM_CH];
    logic        irq_s;

    // Irq mask registers, written by stores to the data region of a channel.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                mask_r[k] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (i_wren && (i_addr[2] == REG_DATA) && (ch_s == ADDR_W'(k))) begin
                    mask_r[k] <= i_wdata;
                end else begin
                    mask_r[k] <= mask_r[k];
                end
            end
        end
    end

    // Any masked flag pending across all channels.
    always_comb begin
        irq_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            irq_s = irq_s | (|(chg_r[k] & mask_r[k]));
        end
    end

    // Registered interrupt output.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= irq_s;
        end
    end
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Scoreboard bench for input_port_ctrl (NUM_CH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_port_ctrl;

    localparam int NUM_CH = 3;
    localparam int AW     = 5;
    localparam logic [2:0] T_LB = 3'b000, T_LH = 3'b001, T_LW = 3'b010,
                           T_LBU = 3'b100, T_LHU = 3'b101, T_BAD = 3'b011;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH*32-1:0] i_raw;
    logic                 i_rden, i_wren;
    logic [AW-1:0]        i_addr;
    logic [2:0]           i_func3;
    logic [31:0]          i_wdata;
    logic [31:0]          o_data;
    logic                 o_valid, o_misalign;
`ifdef INPUT_PORT_IRQ_EN
    logic                 o_irq;
`endif

    input_port_ctrl #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk(clk), .rst_n(rst_n), .i_raw(i_raw), .i_rden(i_rden),
        .i_wren(i_wren), .i_addr(i_addr), .i_func3(i_func3), .i_wdata(i_wdata),
        .o_data(o_data), .o_valid(o_valid), .o_misalign(o_misalign)
`ifdef INPUT_PORT_IRQ_EN
        , .o_irq(o_irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          due;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    $display("FAIL unexpected_valid got data=%h mis=%b, want no valid", o_data, o_misalign);
                end else begin
                    e = sbq.pop_front();
                    if (o_data === e.data && o_misalign === e.mis && cyc == e.due)
                        n_pass++;
                    else
                        $display("FAIL read got data=%h mis=%b cyc=%0d, want data=%h mis=%b cyc=%0d",
                                 o_data, o_misalign, cyc, e.data, e.mis, e.due);
                end
            end
        end
    endtask

    task automatic rd(input logic [1:0] ch, input logic rg, input logic [1:0] off,
                      input logic [2:0] f3, input logic [31:0] ed, input logic em);
        exp_t e;
        i_addr  = {ch, rg, off};
        i_func3 = f3;
        i_rden  = 1'b1;
        e.data = ed; e.mis = em; e.due = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        i_rden = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic rg, input logic [31:0] mask);
        i_addr  = {ch, rg, 2'b00};
        i_wdata = mask;
        i_wren  = 1'b1;
        @(negedge clk);
        i_wren = 1'b0;
    endtask

    task automatic rdwr(input logic [1:0] ch, input logic [31:0] mask, input logic [31:0] ed);
        exp_t e;
        i_addr  = {ch, 1'b1, 2'b00};
        i_func3 = T_LW;
        i_wdata = mask;
        i_rden  = 1'b1;
        i_wren  = 1'b1;
        e.data = ed; e.mis = 1'b0; e.due = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        i_rden = 1'b0;
        i_wren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %b, want %b", name, got, want);
    endtask

    initial begin
        rst_n = 1'b0; i_raw = '0; i_rden = 1'b0; i_wren = 1'b0;
        i_addr = '0; i_func3 = 3'b000; i_wdata = 32'h0;
        fork
            monitor();
        join_none
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_data === 32'h0 && o_valid === 1'b0 && o_misalign === 1'b0) n_pass++;
        else $display("FAIL reset_outputs got data=%h valid=%b mis=%b, want 0/0/0", o_data, o_valid, o_misalign);

        // reset in the middle of a debounce count
        i_raw[31:0] = 32'h0000_00FF;
        idle(3);
        rst_n = 1'b0;
        i_raw[31:0] = 32'h0;
        idle(2);
        rst_n = 1'b1;
        idle(10);
        rd(2'd0, 1'b0, 2'd0, T_LW, 32'h0, 1'b0);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0, 1'b0);

        // settle latency: stable loads on the 7th edge after the raw change
        i_raw[31:0] = 32'h0000_00A5;
        idle(6);
        rd(2'd0, 1'b0, 2'd0, T_LW, 32'h0, 1'b0);
        rd(2'd0, 1'b0, 2'd0, T_LW, 32'h0000_00A5, 1'b0);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_00A5, 1'b0);
        wr(2'd0, 1'b1, 32'hFFFF_FFFF);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0, 1'b0);

        // flags: back to 0, clear, then 0x00 -> 0x05
        i_raw[31:0] = 32'h0;
        idle(10);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_00A5, 1'b0);
        wr(2'd0, 1'b1, 32'hFFFF_FFFF);
        i_raw[31:0] = 32'h0000_0005;
        idle(10);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0005, 1'b0);
        rd(2'd0, 1'b0, 2'd0, T_LW, 32'h0000_0005, 1'b0);
        wr(2'd0, 1'b1, 32'h0000_0001);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0004, 1'b0);

        // glitch rejection on ch1 bit3
        i_raw[35] = 1'b1;
        idle(3);
        i_raw[35] = 1'b0;
        idle(12);
        rd(2'd1, 1'b0, 2'd0, T_LW, 32'h0, 1'b0);
        rd(2'd1, 1'b1, 2'd0, T_LW, 32'h0, 1'b0);

        // load formatting on ch2
        i_raw[95:64] = 32'h8081_F27F;
        idle(10);
        rd(2'd2, 1'b0, 2'd1, T_LB,  32'hFFFF_FFF2, 1'b0);
        rd(2'd2, 1'b0, 2'd3, T_LBU, 32'h0000_0080, 1'b0);
        rd(2'd2, 1'b0, 2'd2, T_LH,  32'hFFFF_8081, 1'b0);
        rd(2'd2, 1'b0, 2'd0, T_LHU, 32'h0000_F27F, 1'b0);
        rd(2'd2, 1'b0, 2'd2, T_LW,  32'h0,         1'b1);
        rd(2'd2, 1'b0, 2'd0, T_LW,  32'h8081_F27F, 1'b0);
        rd(2'd2, 1'b0, 2'd0, T_LB,  32'h0000_007F, 1'b0);
        rd(2'd2, 1'b0, 2'd1, T_LBU, 32'h0000_00F2, 1'b0);
        rd(2'd2, 1'b0, 2'd1, T_LH,  32'h0,         1'b1);
        rd(2'd2, 1'b0, 2'd2, T_LHU, 32'h0000_8081, 1'b0);
        rd(2'd2, 1'b0, 2'd0, T_BAD, 32'h0,         1'b0);
        rd(2'd2, 1'b1, 2'd0, T_LW,  32'h8081_F27F, 1'b0);

        // set and clear of bit0 on the same edge: set wins (chg 4 -> 5)
        i_raw[31:0] = 32'h0000_0004;
        idle(6);
        wr(2'd0, 1'b1, 32'h0000_0001);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0005, 1'b0);

        // read and clear together return the pre-clear value
        rdwr(2'd0, 32'h0000_0004, 32'h0000_0005);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0001, 1'b0);

`ifdef INPUT_PORT_IRQ_EN
        check_bit("irq_unmasked", o_irq, 1'b0);
        wr(2'd0, 1'b0, 32'h0000_0001);
        idle(1);
        check_bit("irq_masked", o_irq, 1'b1);
        wr(2'd0, 1'b1, 32'h0000_0001);
        idle(1);
        check_bit("irq_cleared", o_irq, 1'b0);
        i_raw[31:0] = 32'h0000_0005;
        idle(10);
`endif

        // stores to the data region leave flags alone
        wr(2'd0, 1'b0, 32'hFFFF_FFFF);
`ifdef INPUT_PORT_IRQ_EN
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0001, 1'b0);
        rd(2'd0, 1'b0, 2'd0, T_LW, 32'h0000_0005, 1'b0);
`else
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0001, 1'b0);
        rd(2'd0, 1'b0, 2'd0, T_LW, 32'h0000_0004, 1'b0);
`endif

        // out-of-range channel 3
        wr(2'd3, 1'b1, 32'hFFFF_FFFF);
        rd(2'd3, 1'b0, 2'd0, T_LW, 32'h0, 1'b0);
        rd(2'd3, 1'b1, 2'd0, T_LW, 32'h0, 1'b0);
        rd(2'd0, 1'b1, 2'd0, T_LW, 32'h0000_0001, 1'b0);
        rd(2'd2, 1'b1, 2'd0, T_LW, 32'h8081_F27F, 1'b0);

        idle(3);
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL missing_valid got %0d reads outstanding, want 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
